// File: rtl/vec_mem_stream.sv
// Vector memory with post-reset clear sweep and burst read streaming (valid/ready).
// Define VEC_MEM_COLLISION_FWD_EN for write-first collisions; the default is read-first.
module vec_mem_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_SIZE   = 64,
  parameter int LEN_WIDTH  = 7,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_ready,
  input  logic                  burst_start,
  input  logic [ADDR_WIDTH-1:0] burst_base,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  burst_busy,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_last,
  output logic                  init_done
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_BURST} state_t;

  localparam int                    LP_IW   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0]   LP_SIZE = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(MEM_SIZE - 1);

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;

  logic                  w_clear;
  logic                  w_wr_ok;
  logic                  w_mem_we;
  logic [LP_IW-1:0]      w_mem_idx;
  logic [DATA_WIDTH-1:0] w_mem_wdata;
  logic                  w_issue;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_clear     = (r_state == S_CLEAR);
  assign w_wr_ok     = write_en && ({1'b0, write_address} < LP_SIZE) && !w_clear;
  assign w_mem_we    = w_clear || w_wr_ok;
  assign w_mem_idx   = w_clear ? r_sweep[LP_IW-1:0] : write_address[LP_IW-1:0];
  assign w_mem_wdata = w_clear ? CLEAR_VALUE : data_in;

  assign w_accept = (r_state == S_IDLE) && burst_start && (burst_len != '0) &&
                    ({1'b0, burst_base} < LP_SIZE);
  // The output register is free when empty or being drained this cycle.
  assign w_issue  = (r_state == S_BURST) && (r_remain != '0) && (!rd_valid || rd_ready);

`ifdef VEC_MEM_COLLISION_FWD_EN
  assign w_rd_word = (w_wr_ok && (write_address == r_addr)) ? data_in
                                                             : r_mem[r_addr[LP_IW-1:0]];
`else
  assign w_rd_word = r_mem[r_addr[LP_IW-1:0]];
`endif

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_idx] <= w_mem_wdata;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_CLEAR;
      r_sweep    <= '0;
      r_addr     <= '0;
      r_remain   <= '0;
      wr_ready   <= 1'b0;
      burst_busy <= 1'b0;
      rd_valid   <= 1'b0;
      data_out   <= '0;
      rd_last    <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_sweep == LP_LAST) begin
            r_state   <= S_IDLE;
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
          end else begin
            r_sweep <= r_sweep + ADDR_WIDTH'(1);
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= burst_base;
            r_remain   <= burst_len;
            burst_busy <= 1'b1;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_issue) begin
            data_out <= w_rd_word;
            rd_last  <= (r_remain == LEN_WIDTH'(1));
            rd_valid <= 1'b1;
            r_remain <= r_remain - LEN_WIDTH'(1);
            r_addr   <= (r_addr == LP_LAST) ? '0 : r_addr + ADDR_WIDTH'(1);
          end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_last) begin
              burst_busy <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_stream.sv
// Directed bench for vec_mem_stream; 7-bit addresses so that address 64 is representable.
module tb_vec_mem_stream;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int MS = 64;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          write_en = 1'b0;
  logic [AW-1:0] write_address = '0;
  logic [DW-1:0] data_in = '0;
  logic          wr_ready;
  logic          burst_start = 1'b0;
  logic [AW-1:0] burst_base = '0;
  logic [LW-1:0] burst_len = '0;
  logic          burst_busy;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_last;
  logic          init_done;

  vec_mem_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_address(write_address),
    .data_in(data_in), .wr_ready(wr_ready), .burst_start(burst_start),
    .burst_base(burst_base), .burst_len(burst_len), .burst_busy(burst_busy),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .data_out(data_out),
    .rd_last(rd_last), .init_done(init_done)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] got_data [64];
  logic          got_last [64];
  int            got_cyc  [64];
  int            got_n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_en = 1'b1; write_address = a; data_in = d;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic start_burst(input logic [AW-1:0] b, input logic [LW-1:0] l);
    burst_start = 1'b1; burst_base = b; burst_len = l;
    @(negedge clk);
    burst_start = 1'b0;
  endtask

  task automatic collect(input int n, input bit toggle, input bit poke);
    bit            stalled = 1'b0;
    logic [DW-1:0] sd = '0;
    logic          sl = 1'b0;
    got_n = 0;
    for (int c = 0; c < 300 && got_n < n; c++) begin
      rd_ready = toggle ? (c % 3 == 0) : 1'b1;
      if (poke) begin
        burst_start = (c == 2); burst_base = '0; burst_len = 7'd1;
      end
      if (stalled) begin
        check("stall_data", data_out, sd);
        check("stall_last", rd_last, sl);
        check("stall_valid", rd_valid, 1);
      end
      stalled = rd_valid && !rd_ready;
      sd = data_out; sl = rd_last;
      if (rd_valid && rd_ready) begin
        got_data[got_n] = data_out; got_last[got_n] = rd_last; got_cyc[got_n] = c;
        if (rd_last) check("busy_at_last", burst_busy, 1);
        got_n++;
      end
      @(negedge clk);
    end
    burst_start = 1'b0;
    check("word_count", got_n, n);
  endtask

  logic [DW-1:0] e3 [4];
  int            cnt;

  initial begin
    e3 = '{8'hA2, 8'hA3, 8'hB0, 8'hB1};
    repeat (3) @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", burst_busy, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_last", rd_last, 0);
    check("rst_init", init_done, 0);

    // Sweep timing; a write attempted mid-sweep must be ignored.
    rst_n = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      write_en = (i == 40); write_address = 7'd3; data_in = 8'h99;
      @(negedge clk);
      if (i == 63) begin
        check("init_at_63", init_done, 0);
        check("wrrdy_at_63", wr_ready, 0);
      end
      if (i == 64) begin
        check("init_at_64", init_done, 1);
        check("wrrdy_at_64", wr_ready, 1);
      end
    end
    write_en = 1'b0;

    rd_ready = 1'b1;
    start_burst(7'd0, 7'd64);
    check("t1_busy", burst_busy, 1);
    check("t1_valid_e0", rd_valid, 0);
    collect(64, 1'b0, 1'b0);
    for (int i = 0; i < got_n; i++) begin
      check("t1_data", got_data[i], 0);
      check("t1_last", got_last[i], (i == 63));
      check("t1_cyc", got_cyc[i], i + 1);
    end
    check("t1_busy_end", burst_busy, 0);
    check("t1_valid_end", rd_valid, 0);

    for (int k = 0; k < 10; k++) wr(AW'(k), DW'(k + 1));
    start_burst(7'd2, 7'd4);
    check("t2_valid_e0", rd_valid, 0);
    collect(4, 1'b0, 1'b0);
    for (int i = 0; i < got_n; i++) begin
      check("t2_data", got_data[i], i + 3);
      check("t2_last", got_last[i], (i == 3));
      check("t2_cyc", got_cyc[i], i + 1);
    end
    check("t2_busy_end", burst_busy, 0);

    for (int k = 0; k < 4; k++) wr(AW'(60 + k), DW'(8'hA0 + k));
    for (int k = 0; k < 2; k++) wr(AW'(k), DW'(8'hB0 + k));
    start_burst(7'd62, 7'd4);
    collect(4, 1'b0, 1'b0);
    for (int i = 0; i < got_n; i++) begin
      check("t3_data", got_data[i], e3[i]);
      check("t3_last", got_last[i], (i == 3));
    end

    // Backpressure with a stray burst_start during the burst.
    start_burst(7'd62, 7'd4);
    collect(4, 1'b1, 1'b1);
    for (int i = 0; i < got_n; i++) begin
      check("t4_data", got_data[i], e3[i]);
      check("t4_last", got_last[i], (i == 3));
    end
    check("t4_busy_end", burst_busy, 0);
    check("t4_valid_end", rd_valid, 0);
    @(negedge clk);
    check("t4_busy_after", burst_busy, 0);

    // Collision: write addr 5 on the edge that issues the read of addr 5.
    wr(7'd5, 8'h11);
    rd_ready = 1'b1;
    burst_start = 1'b1; burst_base = 7'd5; burst_len = 7'd1;
    @(negedge clk);
    burst_start = 1'b0;
    write_en = 1'b1; write_address = 7'd5; data_in = 8'h55;
    @(negedge clk);
    write_en = 1'b0;
    check("t5_valid", rd_valid, 1);
    check("t5_last", rd_last, 1);
`ifdef VEC_MEM_COLLISION_FWD_EN
    check("t5_collision", data_out, 8'h55);
`else
    check("t5_collision", data_out, 8'h11);
`endif
    @(negedge clk);
    check("t5_busy_end", burst_busy, 0);
    start_burst(7'd5, 7'd1);
    collect(1, 1'b0, 1'b0);
    check("t5_after_wr", got_data[0], 8'h55);

    // Reset mid-burst.
    rd_ready = 1'b0;
    start_burst(7'd0, 7'd64);
    repeat (3) @(negedge clk);
    check("t6_valid_pre", rd_valid, 1);
    rst_n = 1'b1;
    #1;
    check("t6_valid_rst", rd_valid, 0);
    check("t6_busy_rst", burst_busy, 0);
    check("t6_data_rst", data_out, 0);
    check("t6_last_rst", rd_last, 0);
    check("t6_init_rst", init_done, 0);
    check("t6_wrrdy_rst", wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    cnt = 0;
    while (!init_done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("t6_sweep_len", cnt, 64);
    rd_ready = 1'b1;
    start_burst(7'd5, 7'd1);
    collect(1, 1'b0, 1'b0);
    check("t6_recleared", got_data[0], 0);

    start_burst(7'd0, 7'd0);
    check("len0_ignored", burst_busy, 0);
    @(negedge clk);
    check("len0_valid", rd_valid, 0);
    start_burst(7'd64, 7'd1);
    check("base64_ignored", burst_busy, 0);
    wr(7'd64, 8'h77);
    start_burst(7'd0, 7'd1);
    collect(1, 1'b0, 1'b0);
    check("wr64_dropped", got_data[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_mem_stream.md
Name: vec_mem_stream

Overview:
- Parametrised single-clock vector memory for the dotProduct datapath; successor to the simple read/write operand store.
- Random-access writes; reads are issued as bursts that stream consecutive words out over a valid/ready interface into the MAC pipeline.
- After reset, an internal sweep state machine clears the array instead of clearing it combinationally.
- Provides wrap-around addressing, backpressure, last-word marking and defined write/read collision semantics.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 6, address width; MEM_SIZE <= 2**ADDR_WIDTH.
- MEM_SIZE, 64, number of words; need not be a power of two.
- LEN_WIDTH, 7, burst length field width; max burst = 2**LEN_WIDTH-1.
- CLEAR_VALUE, 0, value written to every word by the post-reset sweep.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted when 1).
- write_en  in  1  write request.
- write_address  in  ADDR_WIDTH  write address.
- data_in  in  DATA_WIDTH  write data.
- wr_ready  out  1  high when writes are accepted (low during the clear sweep).
- burst_start  in  1  one-cycle burst request.
- burst_base  in  ADDR_WIDTH  first read address.
- burst_len  in  LEN_WIDTH  number of words to read.
- burst_busy  out  1  burst in progress.
- rd_valid  out  1  data_out holds a valid word.
- rd_ready  in  1  consumer accepts the word.
- data_out  out  DATA_WIDTH  read word.
- rd_last  out  1  qualifies the final word of a burst.
- init_done  out  1  clear sweep complete.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port is clk; reset port is rst_n, asserted when 1.
- Reset values: wr_ready=0, burst_busy=0, rd_valid=0, data_out=0, rd_last=0, init_done=0. FSM=CLEAR; sweep pointer=0.
- CLEAR state:
  - Writes CLEAR_VALUE to one address per cycle, 0..MEM_SIZE-1, so the sweep takes MEM_SIZE cycles.
  - On the edge that writes MEM_SIZE-1, the FSM moves to IDLE; init_done=1 and wr_ready=1 from that edge on.
  - write_en and burst_start are ignored in CLEAR.
- Writes (IDLE or BURST): when write_en=1 and write_address<MEM_SIZE, data_in is stored at the edge. Writes with write_address>=MEM_SIZE are dropped.
- Burst acceptance:
  - Accepted only in IDLE, when burst_start=1, burst_len!=0 and burst_base<MEM_SIZE; otherwise the request is ignored and there is no error output.
  - At accepting edge E0: latch base and length; FSM=BURST; burst_busy=1.
  - burst_start while BURST or CLEAR is ignored.
- Read issue in BURST:
  - A one-entry output register holds the read word.
  - A read is issued at an edge when words remain and the register is free: rd_valid=0, or rd_valid=1 and rd_ready=1 in the same cycle.
  - Read latency is 1: the first word is issued at E1, so rd_valid=1 after E1.
  - With rd_ready held at 1, one word transfers per cycle.
- Backpressure: while rd_valid=1 and rd_ready=0, data_out and rd_last hold stable and no read is issued.
- Address increment: +1 per issued read; after MEM_SIZE-1 the address wraps to 0, not to 2**ADDR_WIDTH.
- rd_last=1 exactly with the burst_len-th word.
- Burst completion:
  - On the edge where the rd_last word handshakes: rd_valid=0 (no further words), burst_busy=0, FSM=IDLE.
  - A new burst can be accepted from the following cycle.
- Read/write collision (same edge, same address): read-first by default; the stream returns the old contents.
- Reset mid-operation: all outputs drop to reset values immediately (asynchronous); an in-flight burst is abandoned. After release the sweep restarts, so memory contents are re-cleared.

Optional Feature:
- Macro: VEC_MEM_COLLISION_FWD_EN.
- Defined: write-first. When a read is issued at the same edge as a write to the same valid address, data_out takes data_in.
- Undefined: read-first, returning the old memory word.
- Addressing, latency and handshake are identical in both builds.

Test Plan:
- Reset then idle -> wr_ready/init_done rise exactly MEM_SIZE (64) cycles after rst_n falls; a burst of 64 from base 0 returns 0x00 for all words; rd_last only on word 64.
- Write addr k with value k+1 for k=0..9; burst base 2, len 4, rd_ready=1 -> data_out 3,4,5,6 on consecutive cycles; first rd_valid 2 edges after start; rd_last on 6.
- Write 0xA0+k at addr 60..63 and 0xB0+k at addr 0..1; burst base 62, len 4 -> 0xA2, 0xA3, 0xB0, 0xB1 (wrap at MEM_SIZE).
- Same burst with rd_ready toggling 1,0,0,1,... -> data_out stable while stalled; no word lost or duplicated; burst_busy falls on the last handshake; burst_start during burst is ignored.
- Write 0x55 to addr 5 on the same edge the burst issues a read of addr 5 (old 0x11) -> 0x11 without the macro, 0x55 with VEC_MEM_COLLISION_FWD_EN.
- Assert rst_n mid-burst -> rd_valid/burst_busy drop that cycle; after release the sweep runs again and a burst of addr 5 returns 0x00; burst_len=0, write_address=64 and burst_base=64 are all ignored.
